reference_pulse_generator: RTL
==============================

# reference_pulse_generator

Periodic reference-pulse transmitter. It produces the counter-reset pulse train that delayed-trigger logic consumes: a programmable period, a programmable high time, and an optional finite burst length. It sits in the same clock domain as the ADC/DAC sample path. It is armed by software and started by an external start trigger, for example the output of the delayed-trigger block, so that several boards emit phase-aligned reference pulses.

## Interface
Parameters:
- CNT_W, 32, width of all counters and configuration words

Ports:
- clk  input  1  sample clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  global enable; low freezes counters and forces pulse low
- arm  input  1  single-cycle request; IDLE -> ARMED, latches configuration
- stop  input  1  single-cycle request; any state -> IDLE
- start_trigger  input  1  level input; its rising edge starts emission from ARMED
- period  input  CNT_W  pulse period in clk cycles
- pulse_width  input  CNT_W  high time in clk cycles
- num_periods  input  CNT_W  burst length; 0 = run until stop
- pulse  output  1  registered reference pulse
- armed_status  output  1  high in ARMED
- running_status  output  1  high in RUNNING
- done  output  1  one-cycle strobe when a finite burst completes
- phase_counter  output  CNT_W  position within the current period
- period_counter  output  CNT_W  number of completed periods since start

## Operation
- FSM states: IDLE, ARMED, RUNNING.
- IDLE -> ARMED on arm. period, pulse_width and num_periods are latched at that edge; later input changes are ignored until the next arm.
- ARMED -> RUNNING on a start_trigger rising edge. The edge is detected against a registered copy of start_trigger, and that register is also updated in IDLE. If start_trigger is already high when arm occurs, there is no edge and no start.
- RUNNING:
  - phase_counter counts 0..P-1 and wraps.
  - pulse = (phase_counter < W).
  - At each wrap, period_counter increments.
  - If N≠0 and the incremented period_counter equals N, go to IDLE and strobe done for one cycle.
- Any state -> IDLE on stop. In IDLE: pulse = 0, phase_counter = 0, period_counter holds its last value. period_counter clears when entering RUNNING.
- arm while ARMED re-latches the configuration. arm while RUNNING is ignored.
- Clamping of latched values:
  - P = max(period, 2).
  - W = min(pulse_width, P-1).
  - W = 0 gives no pulses, but counting still runs.
- enable low:
  - counters hold, pulse = 0, the FSM holds state, and start_trigger edges are ignored (the edge register still updates).
  - When enable returns, counting resumes from the held phase.
- Simultaneous events:
  - stop beats arm and start_trigger.
  - reset beats everything.
  - A done wrap coincident with stop: go to IDLE with done = 0.
- Arithmetic:
  - Comparisons are unsigned, CNT_W bits.
  - period_counter saturates at all-ones when N = 0.

## Timing
- Reset values of all outputs: pulse = 0, armed_status = 0, running_status = 0, done = 0, phase_counter = 0, period_counter = 0. State = IDLE.
- A start_trigger rising edge sampled at edge k gives, at edge k+1: running_status = 1, phase_counter = 0, period_counter = 0, and pulse = 1 if W > 0.
- Steady state: pulse is high for exactly W cycles every P cycles. It rises when phase_counter = 0.
- armed_status rises 1 cycle after arm and falls in the same cycle running_status rises.
- On the last wrap of a finite burst, the following are all asserted 1 cycle later: done = 1, running_status = 0, pulse = 0, period_counter = N.
- stop at edge k: at edge k+1, pulse = 0 and both status outputs = 0.
- Reset mid-burst: at the next edge all outputs take their reset values. No done strobe.

## Structure
- Package cdt_pkg holds:
  - the state enum (IDLE/ARMED/RUNNING);
  - the CNT_W default;
  - a clamp function for P/W, shared with counter_delayed_trigger for its presamples/reference bounds.
- One natural sub-module, rising_edge_detect: register plus AND-NOT, synchronous active-high reset. It is reused for start_trigger here and can be reused for counter-reset detection elsewhere.
- Everything else is a single always block for the FSM and counters, plus registered outputs.

## Test plan
- period = 250, pulse_width = 10, num_periods = 0; arm, then start_trigger 0→1 → pulse high 10 of every 250 cycles; period_counter = 4 after 1000 running cycles.
- num_periods = 3, period = 100, pulse_width = 5 → exactly 3 pulses; done strobes once at cycle 300 after start; state IDLE; period_counter = 3.
- period = 1, pulse_width = 7 → clamped P = 2, W = 1; pulse toggles 1,0,1,0…
- enable dropped for 40 cycles mid-period at phase 60, period = 250 → pulse low during the gap, phase_counter frozen at 60; next rising edge of pulse delayed by exactly 40 cycles.
- stop and arm in the same cycle while RUNNING → IDLE next cycle, armed_status = 0, pulse = 0; a subsequent start_trigger edge has no effect.
- reset asserted at phase 120 of period 2 → next cycle all outputs 0; start_trigger edges ignored until a fresh arm.

Source files
------------

// File: rtl/cdt_pkg.sv
// Shared definitions for the reference pulse generator and the
// counter-delayed trigger: FSM state encoding, default counter width and
// the period/high-time clamping rules.
package cdt_pkg;

    localparam int CNT_W_DEFAULT = 32;

    // Clamp helpers work on a wide word so any CNT_W up to 64 can share them.
    localparam int CLAMP_W = 64;

    typedef logic [CLAMP_W-1:0] clamp_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2
    } state_t;

    // A period shorter than two cycles cannot hold both a high and a low phase.
    function automatic clamp_word_t clamp_period(input clamp_word_t period);
        return (period < clamp_word_t'(2)) ? clamp_word_t'(2) : period;
    endfunction

    // High time is limited to P-1 so at least one low cycle remains per period.
    function automatic clamp_word_t clamp_width(input clamp_word_t width,
                                                input clamp_word_t p);
        return (width < p) ? width : (p - clamp_word_t'(1));
    endfunction

endpackage

// File: rtl/reference_pulse_generator_if.sv
// Control, configuration and status bundle of the reference pulse generator.
// The master side (software / trigger logic) drives requests and
// configuration; the slave side is the generator itself.
interface reference_pulse_generator_if #(
    parameter int CNT_W = cdt_pkg::CNT_W_DEFAULT
);
    logic             enable;
    logic             arm;
    logic             stop;
    logic             start_trigger;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] pulse_width;
    logic [CNT_W-1:0] num_periods;
    logic             pulse;
    logic             armed_status;
    logic             running_status;
    logic             done;
    logic [CNT_W-1:0] phase_counter;
    logic [CNT_W-1:0] period_counter;

    modport master (
        output enable, arm, stop, start_trigger, period, pulse_width, num_periods,
        input  pulse, armed_status, running_status, done, phase_counter, period_counter
    );

    modport slave (
        input  enable, arm, stop, start_trigger, period, pulse_width, num_periods,
        output pulse, armed_status, running_status, done, phase_counter, period_counter
    );
endinterface

// File: rtl/reference_pulse_generator_rising_edge_detect.sv
// Single-cycle rising-edge detector: registered copy of the input and an
// AND-NOT against the live value. The register updates every cycle so a level
// already high when a consumer starts looking never reads as an edge.
module rising_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;

    // Delay register for the edge comparison.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/reference_pulse_generator.sv
// Periodic reference-pulse transmitter. Armed by software, started by a
// start_trigger rising edge, it emits a pulse of W cycles every P cycles,
// optionally for a finite burst of N periods. All outputs are registered.
// A stop request is honoured even while enable is low; every other state
// change waits for enable.
module reference_pulse_generator
    import cdt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    reference_pulse_generator_if.slave   bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;

    logic             trig_rise;
    logic [CNT_W-1:0] p_clamped;
    logic [CNT_W-1:0] w_clamped;
    logic             wrap;
    logic [CNT_W-1:0] pcnt_inc;

    rising_edge_detect u_trig_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (bus.start_trigger),
        .rise_o (trig_rise)
    );

    assign p_clamped = CNT_W'(clamp_period(clamp_word_t'(bus.period)));
    assign w_clamped = CNT_W'(clamp_width(clamp_word_t'(bus.pulse_width),
                                          clamp_period(clamp_word_t'(bus.period))));

    assign wrap     = (phase_q == (p_q - 1'b1));
    // Saturates at all-ones; a finite burst always ends before reaching it.
    assign pcnt_inc = (&pcnt_q) ? pcnt_q : (pcnt_q + 1'b1);

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            pcnt_q  <= '0;
            // NOTE: configuration registers are reset too; they are a few
            // flops, not a memory array, and a defined value keeps sims clean.
            p_q     <= CNT_W'(2);
            w_q     <= '0;
            n_q     <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
            p_q     <= p_d;
            w_q     <= w_d;
            n_q     <= n_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d = state_q;
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        p_d     = p_q;
        w_d     = w_q;
        n_d     = n_q;
        pulse_d = 1'b0;
        done_d  = 1'b0;

        if (bus.stop) begin
            // Stop wins over arm, start and a coincident final wrap.
            state_d = IDLE;
            phase_d = '0;
        end else if (bus.enable) begin
            case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        state_d = ARMED;
                        p_d     = p_clamped;
                        w_d     = w_clamped;
                        n_d     = bus.num_periods;
                    end
                end
                ARMED: begin
                    if (trig_rise) begin
                        state_d = RUNNING;
                        phase_d = '0;
                        pcnt_d  = '0;
                        pulse_d = (w_q != '0);
                    end else if (bus.arm) begin
                        p_d = p_clamped;
                        w_d = w_clamped;
                        n_d = bus.num_periods;
                    end
                end
                RUNNING: begin
                    if (wrap) begin
                        phase_d = '0;
                        pcnt_d  = pcnt_inc;
                        if ((n_q != '0) && (pcnt_inc == n_q)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                    pulse_d = (state_d == RUNNING) && (phase_d < w_q);
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    assign bus.pulse          = pulse_q;
    assign bus.done           = done_q;
    assign bus.armed_status   = (state_q == ARMED);
    assign bus.running_status = (state_q == RUNNING);
    assign bus.phase_counter  = phase_q;
    assign bus.period_counter = pcnt_q;
endmodule
